// File: rtl/oled_task_arbiter_pkg.sv
// Shared constants, FSM state encoding and RGB565 helpers for the OLED task arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package oled_pkg;

  localparam int OLED_W    = 96;
  localparam int OLED_H    = 64;
  localparam int PIX_COUNT = OLED_W * OLED_H;

  // Owner / target code meaning "nobody".
  localparam logic [2:0] NO_TASK = 3'd7;

  // Arbiter FSM, 2-bit encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE       = 2'd0;
  localparam state_t ST_WAIT_FRAME = 2'd1;
  localparam state_t ST_BLANK      = 2'd2;
  localparam state_t ST_ACTIVE     = 2'd3;

  // RGB565 colours.
  localparam logic [15:0] BLACK = 16'h0000;
  localparam logic [15:0] RED   = 16'hF800;
  localparam logic [15:0] GREEN = 16'h07E0;

  // Extract task idx's RGB565 word from the packed four-task pixel bus.
  function automatic logic [15:0] task_word(input logic [63:0] data, input logic [1:0] idx);
    return data[16*idx +: 16];
  endfunction

endpackage

// File: rtl/oled_task_arbiter_if.sv
// Pixel/control bundle between the display tasks, the OLED driver and the arbiter.
// Latency: none (wires only).
// Backpressure: none; the pixel stream is free-running, driven by the OLED driver timing.
// Signals: switch (raw slide switches), frame_begin (frame wrap pulse), pixel_index
// (current pixel), task_data (4 packed RGB565 words), task_enable (one-hot run enable),
// oled_data (pixel to driver), active_task (owner, 7 = none), switching (owner change in progress).
interface oled_task_arbiter_if;

  logic [15:0] switch;
  logic        frame_begin;
  logic [12:0] pixel_index;
  logic [63:0] task_data;
  logic [3:0]  task_enable;
  logic [15:0] oled_data;
  logic [2:0]  active_task;
  logic        switching;

  // Task/driver/stimulus side.
  modport master (
    output switch, frame_begin, pixel_index, task_data,
    input  task_enable, oled_data, active_task, switching
  );

  // Arbiter side.
  modport slave (
    input  switch, frame_begin, pixel_index, task_data,
    output task_enable, oled_data, active_task, switching
  );

endinterface

// File: rtl/oled_task_arbiter_switch_code_filter.sv
// Synchronises the slide switches, decodes them against per-task keys and debounces the result.
// Latency: a switch edge reaches accepted_target_o 2+STABLE_CYCLES clocks later.
// Backpressure: none; output is a level that simply holds until a new code qualifies.
// Ports: clk_i, rst_n_i (async active-low), switch_i (raw, asynchronous),
// accepted_target_o (index of the matching task, 7 when no key matches).
module switch_code_filter
  import oled_pkg::*;
#(
  parameter int          NUM_TASKS     = 4,
  parameter logic [15:0] KEY_0         = 16'h0001,
  parameter logic [15:0] KEY_1         = 16'h0002,
  parameter logic [15:0] KEY_2         = 16'h0004,
  parameter logic [15:0] KEY_3         = 16'h0008,
  parameter int          STABLE_CYCLES = 1000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [15:0] switch_i,
  output logic [2:0]  accepted_target_o
);

  localparam int            CW       = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [63:0]   KEYS     = {KEY_3, KEY_2, KEY_1, KEY_0};

  logic [15:0]   sync1_q, sync2_q;
  logic [3:0]    hit;
  logic [2:0]    decoded;
  logic [2:0]    dec_prev_q;
  logic [2:0]    accepted_q, accepted_d;
  logic [CW-1:0] stab_cnt_q, stab_cnt_d;

  for (genvar g = 0; g < 4; g++) begin : g_hit
    if (g < NUM_TASKS) begin : g_live
      assign hit[g] = (sync2_q == KEYS[16*g +: 16]);
    end else begin : g_dead
      assign hit[g] = 1'b0;
    end
  end

  // Lowest matching task wins if two keys happen to be identical.
  always_comb begin
    decoded = NO_TASK;
    if      (hit[0]) decoded = 3'd0;
    else if (hit[1]) decoded = 3'd1;
    else if (hit[2]) decoded = 3'd2;
    else if (hit[3]) decoded = 3'd3;
  end

  // stab_cnt counts how many consecutive cycles the decoded code has repeated;
  // the code is accepted on the edge the count lands on STABLE_CYCLES-1.
  always_comb begin
    stab_cnt_d = '0;
    if (decoded == dec_prev_q) begin
      stab_cnt_d = (stab_cnt_q == CNT_LAST) ? stab_cnt_q : stab_cnt_q + 1'b1;
    end
    accepted_d = (stab_cnt_d == CNT_LAST) ? decoded : accepted_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      dec_prev_q <= NO_TASK;
      stab_cnt_q <= '0;
      accepted_q <= NO_TASK;
    end else begin
      sync1_q    <= switch_i;
      sync2_q    <= sync1_q;
      dec_prev_q <= decoded;
      stab_cnt_q <= stab_cnt_d;
      accepted_q <= accepted_d;
    end
  end

  assign accepted_target_o = accepted_q;

endmodule

// File: rtl/oled_task_arbiter.sv
// Grants the single OLED pixel stream to at most one display task, changing owner only on frame boundaries.
// Latency: oled_data is the owner's word one clock later; an owner change costs BLANK_FRAMES black frames.
// Backpressure: none; non-owners are held in reset via task_enable instead of being stalled.
// Ports: sclk_6p25mhz (pixel clock), rst_n (async active-low), bus (slave side of
// oled_task_arbiter_if: switch, frame_begin, pixel_index, task_data in; task_enable,
// oled_data, active_task, switching out).
module oled_task_arbiter
  import oled_pkg::*;
#(
  parameter int          NUM_TASKS     = 4,
  parameter logic [15:0] KEY_0         = 16'h0001,
  parameter logic [15:0] KEY_1         = 16'h0002,
  parameter logic [15:0] KEY_2         = 16'h0004,
  parameter logic [15:0] KEY_3         = 16'h0008,
  parameter int          STABLE_CYCLES = 1000,
  parameter int          BLANK_FRAMES  = 2
) (
  input  logic               sclk_6p25mhz,
  input  logic               rst_n,
  oled_task_arbiter_if.slave bus
);

  localparam int            BW      = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;
  localparam logic [BW-1:0] BF_LAST = BW'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);

  logic [2:0]    tgt;
  state_t        state_q, state_d;
  logic [2:0]    pending_q, pending_d;
  logic [2:0]    active_q, active_d;
  logic [3:0]    enable_q, enable_d;
  logic [BW-1:0] blank_q, blank_d;
  logic [15:0]   oled_q, oled_d;

  switch_code_filter #(
    .NUM_TASKS    (NUM_TASKS),
    .KEY_0        (KEY_0),
    .KEY_1        (KEY_1),
    .KEY_2        (KEY_2),
    .KEY_3        (KEY_3),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk_i            (sclk_6p25mhz),
    .rst_n_i          (rst_n),
    .switch_i         (bus.switch),
    .accepted_target_o(tgt)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    blank_d   = blank_q;

    case (state_q)
      ST_IDLE: begin
        if (tgt != NO_TASK) begin
          pending_d = tgt;
          state_d   = ST_WAIT_FRAME;
        end
      end
      ST_WAIT_FRAME: begin
        if (tgt == NO_TASK) begin
          state_d = ST_IDLE;
        end else begin
          pending_d = tgt;
        end
      end
      ST_BLANK: begin
        if (tgt == NO_TASK) begin
          state_d = ST_IDLE;
        end else if (tgt != pending_q) begin
          // A retarget mid-frame falls back to waiting for the next boundary,
          // so the new task always gets BLANK_FRAMES complete black frames.
          pending_d = tgt;
          blank_d   = '0;
          state_d   = ST_WAIT_FRAME;
        end else if (bus.frame_begin) begin
          if (blank_q == BF_LAST) begin
            state_d = ST_ACTIVE;
          end else begin
            blank_d = blank_q + 1'b1;
          end
        end
      end
      default: begin // ST_ACTIVE
        if (tgt != active_q) begin
          if (tgt == NO_TASK) begin
            state_d = ST_IDLE;
          end else begin
            pending_d = tgt;
            state_d   = ST_WAIT_FRAME;
          end
        end
      end
    endcase

    // The target change is resolved first; a frame_begin in that same cycle
    // is then the blanking boundary for the (possibly new) pending task.
    if (state_d == ST_WAIT_FRAME && bus.frame_begin) begin
      blank_d = '0;
      state_d = (BLANK_FRAMES == 0) ? ST_ACTIVE : ST_BLANK;
    end

    // Owner and enable are registered from the next state so both move on the same edge.
    active_d = NO_TASK;
    enable_d = 4'b0000;
    if (state_d == ST_ACTIVE) begin
      active_d = pending_d;
      enable_d = 4'b0001 << pending_d[1:0];
    end

    // Forward pixels only while the same owner holds across the edge: the first
    // cycle after a grant and the first cycle after a drop are both black.
    oled_d = BLACK;
    if (state_q == ST_ACTIVE && state_d == ST_ACTIVE && active_d == active_q) begin
      oled_d = task_word(bus.task_data, active_q[1:0]);
    end
  end

  always_ff @(posedge sclk_6p25mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= NO_TASK;
      active_q  <= NO_TASK;
      enable_q  <= 4'b0000;
      blank_q   <= '0;
      oled_q    <= BLACK;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      enable_q  <= enable_d;
      blank_q   <= blank_d;
      oled_q    <= oled_d;
    end
  end

  assign bus.task_enable = enable_q;
  assign bus.active_task = active_q;
  assign bus.oled_data   = oled_q;
  assign bus.switching   = (state_q == ST_WAIT_FRAME) || (state_q == ST_BLANK);

  // The driver only ever presents on-screen pixel indices.
  pix_range_a: assert property (@(posedge sclk_6p25mhz) disable iff (!rst_n)
    bus.pixel_index < 13'(PIX_COUNT));

endmodule

// File: tb/tb_oled_task_arbiter.sv
module tb_oled_task_arbiter;
  import oled_pkg::*;

  localparam int S  = 4;
  localparam int BF = 2;
  localparam logic [63:0] TD_FIXED = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0540};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  oled_task_arbiter_if bus();

  oled_task_arbiter #(
    .NUM_TASKS(4), .KEY_0(16'h0001), .KEY_1(16'h0002), .KEY_2(16'h0004), .KEY_3(16'h0008),
    .STABLE_CYCLES(S), .BLANK_FRAMES(BF)
  ) dut (
    .sclk_6p25mhz(clk),
    .rst_n       (rst_n),
    .bus         (bus)
  );

  int checks = 0;
  int errors = 0;
  int pix    = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Filter: accepted code = decode of the switch sampled 2..S+1 edges ago, when those S samples agree.
  // Ownership: a request needs BF+1 frame boundaries (the first ends the live frame) before it is granted.
  logic [15:0] hist[$];
  int          acc_m;
  int          owner_m;   // -1: nobody owns the OLED
  int          want_m;    // requested task, 7 = none
  int          nb_m;      // frame boundaries seen for want_m
  logic [15:0] oled_m;

  function automatic int decode(input logic [15:0] sw);
    case (sw)
      16'h0001: return 0;
      16'h0002: return 1;
      16'h0004: return 2;
      16'h0008: return 3;
      default:  return 7;
    endcase
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < S + 2; i++) hist.push_back(16'h0000);
    acc_m   = 7;
    owner_m = -1;
    want_m  = 7;
    nb_m    = 0;
    oled_m  = 16'h0000;
  endtask

  // Called just after a rising edge; bus inputs still hold their pre-edge values.
  task automatic model_step();
    int  tgt;
    int  prev_owner;
    int  d0;
    bit  same;
    tgt        = acc_m;
    prev_owner = owner_m;
    if (owner_m >= 0) begin
      if (tgt != owner_m) begin
        owner_m = -1;
        want_m  = tgt;
        nb_m    = 0;
      end
    end else if (tgt != want_m) begin
      want_m = tgt;
      nb_m   = 0;
    end
    if (owner_m < 0 && want_m != 7 && bus.frame_begin) begin
      nb_m++;
      if (nb_m == BF + 1) owner_m = want_m;
    end
    oled_m = (prev_owner >= 0 && owner_m == prev_owner) ? bus.task_data[16*prev_owner +: 16] : 16'h0000;

    hist.push_front(bus.switch);
    void'(hist.pop_back());
    d0   = decode(hist[2]);
    same = 1'b1;
    for (int i = 3; i <= S + 1; i++) if (decode(hist[i]) != d0) same = 1'b0;
    if (same) acc_m = d0;
  endtask

  function automatic logic [3:0] exp_en(input int o);
    return (o >= 0) ? 4'(1 << o) : 4'b0000;
  endfunction

  function automatic logic [2:0] exp_act(input int o);
    return (o >= 0) ? 3'(o) : 3'd7;
  endfunction

  task automatic check_model();
    check("model.task_enable", 16'(bus.task_enable), 16'(exp_en(owner_m)));
    check("model.active_task", 16'(bus.active_task), 16'(exp_act(owner_m)));
    check("model.switching",   16'(bus.switching),   16'(owner_m < 0 && want_m != 7));
    check("model.oled_data",   bus.oled_data,        oled_m);
    checks++;
    if (!$onehot0(bus.task_enable) || ((bus.active_task == 3'd7) != (bus.task_enable == 4'b0000))) begin
      errors++;
      $display("FAIL onehot_owner: task_enable=%b active_task=%0d", bus.task_enable, bus.active_task);
    end
  endtask

  task automatic drive(input logic [15:0] sw, input logic fb, input logic [63:0] td);
    bus.switch      = sw;
    bus.frame_begin = fb;
    bus.task_data   = td;
    pix             = fb ? 0 : (pix + 1) % PIX_COUNT;
    bus.pixel_index = 13'(pix);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".task_enable"}, 16'(bus.task_enable), 16'h0000);
    check({tag, ".active_task"}, 16'(bus.active_task), 16'h0007);
    check({tag, ".switching"},   16'(bus.switching),   16'h0000);
    check({tag, ".oled_data"},   bus.oled_data,        16'h0000);
  endtask

  // Asynchronous reset pulse placed mid-cycle; outputs must clear before any edge.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [15:0] sw;
    logic        fb;    // frame_begin in the first cycle of the row
    int          cyc;
    logic [3:0]  en;
    logic [2:0]  act;
    logic        swo;
    logic [15:0] oled;
  } vec_t;

  vec_t tbl[26];

  task automatic run_rows(input int first, input int last);
    for (int r = first; r <= last; r++) begin
      for (int c = 0; c < tbl[r].cyc; c++) begin
        drive(tbl[r].sw, (c == 0) ? tbl[r].fb : 1'b0, TD_FIXED);
        tick();
      end
      check($sformatf("row%0d.task_enable", r), 16'(bus.task_enable), 16'(tbl[r].en));
      check($sformatf("row%0d.active_task", r), 16'(bus.active_task), 16'(tbl[r].act));
      check($sformatf("row%0d.switching", r),   16'(bus.switching),   16'(tbl[r].swo));
      check($sformatf("row%0d.oled_data", r),   bus.oled_data,        tbl[r].oled);
    end
  endtask

  initial begin
    //              sw        fb  cyc  en       act   swo   oled
    tbl[0]  = '{16'h0001, 1'b0, 6, 4'b0000, 3'd7, 1'b0, 16'h0000}; // code accepted, FSM not yet moved
    tbl[1]  = '{16'h0001, 1'b0, 1, 4'b0000, 3'd7, 1'b1, 16'h0000}; // WAIT_FRAME
    tbl[2]  = '{16'h0001, 1'b1, 1, 4'b0000, 3'd7, 1'b1, 16'h0000}; // BLANK
    tbl[3]  = '{16'h0001, 1'b0, 5, 4'b0000, 3'd7, 1'b1, 16'h0000};
    tbl[4]  = '{16'h0001, 1'b1, 1, 4'b0000, 3'd7, 1'b1, 16'h0000};
    tbl[5]  = '{16'h0001, 1'b0, 5, 4'b0000, 3'd7, 1'b1, 16'h0000};
    tbl[6]  = '{16'h0001, 1'b1, 1, 4'b0001, 3'd0, 1'b0, 16'h0000}; // granted, first pixel black
    tbl[7]  = '{16'h0001, 1'b0, 1, 4'b0001, 3'd0, 1'b0, 16'h0540};
    tbl[8]  = '{16'h0002, 1'b0, 3, 4'b0001, 3'd0, 1'b0, 16'h0540}; // glitch
    tbl[9]  = '{16'h0001, 1'b0, 6, 4'b0001, 3'd0, 1'b0, 16'h0540};
    tbl[10] = '{16'h0004, 1'b0, 6, 4'b0001, 3'd0, 1'b0, 16'h0540};
    tbl[11] = '{16'h0004, 1'b0, 1, 4'b0000, 3'd7, 1'b1, 16'h0000}; // drop owner
    tbl[12] = '{16'h0004, 1'b1, 4, 4'b0000, 3'd7, 1'b1, 16'h0000};
    tbl[13] = '{16'h0004, 1'b1, 4, 4'b0000, 3'd7, 1'b1, 16'h0000};
    tbl[14] = '{16'h0004, 1'b1, 1, 4'b0100, 3'd2, 1'b0, 16'h0000};
    tbl[15] = '{16'h0004, 1'b0, 1, 4'b0100, 3'd2, 1'b0, 16'hFFFF};
    tbl[16] = '{16'h0001, 1'b0, 7, 4'b0000, 3'd7, 1'b1, 16'h0000};
    tbl[17] = '{16'h0001, 1'b1, 1, 4'b0000, 3'd7, 1'b1, 16'h0000};
    tbl[18] = '{16'h0001, 1'b1, 1, 4'b0000, 3'd7, 1'b1, 16'h0000}; // one blank frame done
    tbl[19] = '{16'h0008, 1'b0, 7, 4'b0000, 3'd7, 1'b1, 16'h0000}; // retarget mid-blank
    tbl[20] = '{16'h0008, 1'b1, 1, 4'b0000, 3'd7, 1'b1, 16'h0000}; // old target would be granted here
    tbl[21] = '{16'h0008, 1'b1, 1, 4'b0000, 3'd7, 1'b1, 16'h0000};
    tbl[22] = '{16'h0008, 1'b1, 1, 4'b1000, 3'd3, 1'b0, 16'h0000};
    tbl[23] = '{16'h0008, 1'b0, 2, 4'b1000, 3'd3, 1'b0, 16'hFFFF};
    tbl[24] = '{16'h1234, 1'b0, 6, 4'b1000, 3'd3, 1'b0, 16'hFFFF};
    tbl[25] = '{16'h1234, 1'b0, 1, 4'b0000, 3'd7, 1'b0, 16'h0000}; // back to IDLE

    model_reset();
    drive(16'h0001, 1'b0, TD_FIXED);
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    run_rows(0, 25);

    // Reset during ACTIVE, then the full qualify/blank sequence again.
    run_rows(0, 7);
    async_reset("midframe_reset");
    run_rows(0, 7);

    // Randomised phase against the reference model.
    begin
      logic [15:0] sw;
      int          hold;
      int          r;
      sw   = 16'h0001;
      hold = 0;
      for (int n = 0; n < 4000; n++) begin
        if (hold == 0) begin
          r = $urandom_range(0, 5);
          if (r < 4)       sw = 16'(1 << r);
          else if (r == 4) sw = 16'h0000;
          else             sw = 16'($urandom);
          hold = $urandom_range(1, 14);
        end
        hold--;
        drive(sw, ($urandom_range(0, 7) == 0), {$urandom, $urandom});
        tick();
        if ($urandom_range(0, 999) == 0) async_reset("rand_reset");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/oled_task_arbiter.md
Name: oled_task_arbiter

Overview:
- Owns the single 96x64 OLED pixel stream and shares it among NUM_TASKS display tasks (ring task, etc.).
- Decodes the 16 slide switches against per-task unlock keys and grants the OLED to at most one task.
- Switches owner only at frame boundaries, inserting blank frames in between, and holds non-owning tasks in reset via task_enable.
- Sits between the task modules and the OLED driver, in the pixel-clock domain.

Parameters:
- NUM_TASKS, 4, number of requesting tasks; legal range 1..4.
- KEY_0, 16'h0001, switch code that selects task 0.
- KEY_1, 16'h0002, switch code that selects task 1.
- KEY_2, 16'h0004, switch code that selects task 2.
- KEY_3, 16'h0008, switch code that selects task 3.
- STABLE_CYCLES, 1000, consecutive clocks a decoded code must hold before it is accepted; minimum 1.
- BLANK_FRAMES, 2, full black frames inserted on every change of owner; 0 is allowed.

Ports:
- sclk_6p25mhz, input, 1: pixel clock, shared with the OLED driver.
- rst_n, input, 1: asynchronous, active-low reset.
- switch, input, 16: raw slide switches; asynchronous to the clock.
- frame_begin, input, 1: one-cycle pulse from the OLED driver, asserted when pixel_index wraps to 0.
- pixel_index, input, 13: current pixel, 0..6143; pass-through only, used for assertions.
- task_data, input, 64: four packed RGB565 words; task i occupies bits [16i+15:16i].
- task_enable, output, 4: one-hot run enable per task; a task whose bit is low holds its own state in reset.
- oled_data, output, 16: RGB565 pixel sent to the OLED driver.
- active_task, output, 3: index of the current owner; 3'd7 means no owner.
- switching, output, 1: high while in the WAIT_FRAME or BLANK state.

Behaviour:
- Reset values: oled_data=0, task_enable=0, active_task=7, switching=0, state=IDLE, all counters 0, sync flops 0.
- switch passes through a 2-flop synchronizer, then a decoder.
  - Decoded target: lowest i < NUM_TASKS with sync_switch==KEY_i; if none match, target is 7.
- Stability filter:
  - stab_cnt resets to 0 whenever the decoded value differs from the previous cycle's decoded value; otherwise it increments and saturates.
  - accepted_target updates when stab_cnt reaches STABLE_CYCLES-1.
  - Latency from a switch edge to accepted_target is 2+STABLE_CYCLES clocks.
- FSM states: IDLE, WAIT_FRAME, BLANK, ACTIVE.
  - IDLE: output black, owner 7. If accepted_target != 7, latch it into pending and go to WAIT_FRAME.
  - WAIT_FRAME: task_enable=0, output black. On frame_begin, go to BLANK with blank_cnt=0, or go directly to ACTIVE if BLANK_FRAMES=0.
  - BLANK: output black; blank_cnt increments on each frame_begin. When frame_begin arrives with blank_cnt==BLANK_FRAMES-1, go to ACTIVE.
  - Entering ACTIVE: active_task=pending and task_enable=1<<pending, both on the same edge.
  - ACTIVE: if accepted_target differs from active_task, latch pending=accepted_target, drop task_enable and active_task on the next edge, and go to WAIT_FRAME. If the new target is 7, go to IDLE instead.
- New accepted target during WAIT_FRAME or BLANK:
  - Overwrite pending.
  - In BLANK, restart blank_cnt at 0 so the new task always gets a full blanking period.
  - Target 7 in either state returns to IDLE.
- Datapath:
  - oled_data is registered: the word the owner presents in cycle n appears on oled_data in cycle n+1.
  - oled_data is 16'h0000 in every state except ACTIVE.
- frame_begin in the same cycle as a target change: the target change is evaluated first (pending updates), and that frame_begin still counts as the boundary for the new pending.
- Reset mid-blank or mid-frame: all outputs return to reset values immediately; after release the block starts from IDLE and the filter must re-qualify the switch code.
- Assertion (bench): task_enable is always one-hot or zero, and active_task==7 exactly when task_enable==0.

Decomposition:
- Shared package oled_pkg holds:
  - OLED_W=96, OLED_H=64, PIX_COUNT=6144.
  - NO_TASK=3'd7.
  - The FSM state typedef (2-bit encoding).
  - The RGB565 colour constants BLACK=16'h0000, RED, GREEN.
- One natural sub-module, switch_code_filter: the synchronizer, decoder and stability counter, producing accepted_target. It is reusable by other switch-driven blocks.

Test Plan:
1. Reset release with switch=16'h0001 and STABLE_CYCLES=4: accepted_target goes valid 6 clocks after reset. On the first frame_begin the state goes to BLANK; after 2 more frame_begins, task_enable=4'b0001 and active_task=0.
2. ACTIVE on task 0, with task_data word 0 = 16'h0540: oled_data=16'h0540 one clock after the data appears. Words 1..3 = 16'hFFFF never reach oled_data.
3. Owner is 0 and switch goes to 16'h0004: task_enable drops to 0 within 1 clock after acceptance, then 2 full black frames, then task_enable=4'b0100 aligned to a frame_begin.
4. Glitch: switch=16'h0002 for 3 clocks then back to 16'h0001 (STABLE_CYCLES=4): no state change and oled_data is unchanged.
5. In BLANK after 1 frame, switch changes to 16'h0008: blank_cnt restarts, so 2 further full black frames pass before task 3 is enabled. Then switch=16'h1234 returns the block to IDLE with oled_data=0 and active_task=7.
6. Assert rst_n low mid-frame during ACTIVE: outputs reach reset values asynchronously, before the next clock edge. After release with the switch unchanged, the full re-qualification and blanking sequence is repeated.
